reg_path_checker: RTL and testbench
===================================

# reg_path_checker

Synthesizable response checker for a registered datapath such as a D flip-flop or short register pipeline. Samples the stimulus driven into the path (`d_obs`) and the path output (`q_obs`), delays the stimulus by `LATENCY` clocks, and compares it with the observed output every enabled cycle. Sits beside a DUT in a self-checking bench or on-chip BIST wrapper and reports pass/fail status and mismatch counts without simulator-side `$monitor` checks.

## Interface
- `WIDTH`, 8: data width of `d_obs`/`q_obs`.
- `LATENCY`, 1: path latency in clocks; legal range 1..8.
- `ERRW`, 8: width of the mismatch counter.

- `clk` in 1: clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `en` in 1: checking enabled; deassert flushes the pipeline.
- `clr` in 1: synchronous clear of counters and sticky flags.
- `d_obs` in WIDTH: stimulus presented to the DUT.
- `q_obs` in WIDTH: DUT output.
- `busy` out 1: high in FILL or CHECK.
- `checking` out 1: high in CHECK.
- `fail` out 1: sticky; set on the first mismatch.
- `err_cnt` out ERRW: mismatch count, saturating.
- `chk_cnt` out 16: number of comparisons performed, saturating.
- `first_exp` out WIDTH: expected value of the first mismatch.
- `first_obs` out WIDTH: observed value of the first mismatch.

## Operation
- Expected pipeline: `exp[0..LATENCY-1]` with valid bits `vld[0..LATENCY-1]`. Each edge with `en`=1: `exp[0]`<=`d_obs`, `vld[0]`<=1, stage i<=stage i-1. With `en`=0, all `vld` clear and contents are don't-care.
- Comparison is performed at an edge when `en`=1 and `vld[LATENCY-1]`=1. It compares `q_obs` with `exp[LATENCY-1]`, which holds `d_obs` sampled `LATENCY` edges earlier.
- FSM states:
  - IDLE: `en`=1 -> FILL.
  - FILL: the pipeline is filling. When `vld[LATENCY-2]` is set at the edge (for `LATENCY`=1, immediately), go to CHECK. `en`=0 -> IDLE.
  - CHECK: compare each edge. `en`=0 -> IDLE.
- On each comparison:
  - `chk_cnt`+1, saturating at 0xFFFF.
  - On mismatch: `err_cnt`+1, saturating at 2^ERRW-1, and `fail`<=1.
- Counters, `fail`, `first_*` hold through `en`=0. Only `clr` or reset clears them.
- `clr`=1 has priority over a same-edge comparison. Counters/flags go to 0 and the comparison result for that edge is discarded. The FSM and pipeline are unaffected.
- Reset mid-operation: all state returns to reset values immediately. There is no partial-count retention.

## Timing
- Reset values: FSM=IDLE, all `vld`=0. `busy`, `checking`, `fail`, `err_cnt`, `chk_cnt`, `first_exp`, `first_obs` are all 0.
- All outputs are registered. A mismatch sampled at edge k is visible on `fail`/`err_cnt` after edge k.
- The first comparison occurs at the (`LATENCY`+1)th enabled edge after IDLE.
- `en` toggling low for a single cycle forces a full refill. No comparisons occur for `LATENCY` enabled edges afterward.
- `busy` asserts after the first enabled edge. `checking` asserts after the edge that enters CHECK.

## Configuration
- `REG_PATH_CHECKER_FIRST_ERR_EN`
  - Defined: `first_exp`/`first_obs` capture the expected/observed values on the comparison that first sets `fail`. They hold until `clr` or reset; later mismatches do not overwrite them.
  - Undefined: the capture registers are not built, and `first_exp`/`first_obs` are tied to 0. All other behaviour is identical.

## Test plan
1. **Correct DFF, LATENCY=1.** Drive `d_obs`=0,1,2,3,4 on consecutive cycles with `q_obs` = `d_obs` delayed one clock, `en`=1 throughout. Required: `fail`=0, `err_cnt`=0, `chk_cnt`=4 after the 5th edge.
2. **Injected error.** Same as scenario 1, but force `q_obs`=7 at the 3rd comparison (expected 2). Required:
   - `fail`=1 and `err_cnt`=1 after that edge.
   - With the macro defined: `first_exp`=2, `first_obs`=7. Without it, both read 0.
3. **LATENCY=3 fill.** `en`=1 from IDLE. Required:
   - No `chk_cnt` change at edges 1–3; `chk_cnt`=1 after edge 4.
   - `checking`=1 after edge 3.
4. **en drop.** Deassert `en` for 1 cycle mid-CHECK with garbage `q_obs`. Required:
   - No `err_cnt` change; `busy`=0 after that edge.
   - Refill of `LATENCY` edges before comparisons resume.
5. **Saturation and clr.** Use ERRW=2 with 5 consecutive mismatches. Required: `err_cnt`=3. Then assert `clr` on an edge that also carries a mismatch; required: `err_cnt`=0, `fail`=0, `chk_cnt`=0 after that edge.
6. **Async reset.** Pull `rstn` low between clock edges while in CHECK with `err_cnt`=2. Required: all outputs are 0 immediately, before the next edge, and the FSM is IDLE.

Source files
------------

// File: rtl/reg_path_checker.sv
// reg_path_checker: response checker for a registered datapath.
// The stimulus d_obs is delayed LATENCY clocks and compared with q_obs on
// every enabled cycle. It reports a sticky fail flag, a saturating mismatch
// count and a saturating comparison count.
// Optional feature: define REG_PATH_CHECKER_FIRST_ERR_EN to build the
// first-mismatch capture registers (first_exp/first_obs). Without the macro
// those outputs are tied to 0.
module reg_path_checker #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int ERRW    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_obs,
  input  logic [WIDTH-1:0] q_obs,
  output logic             busy,
  output logic             checking,
  output logic             fail,
  output logic [ERRW-1:0]  err_cnt,
  output logic [15:0]      chk_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_obs
);

  // Bit 0 marks "busy", bit 1 marks "checking", so both outputs are plain
  // register bits.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] FILL  = 2'b01;
  localparam logic [1:0] CHECK = 2'b11;

  logic [1:0]                    state_q, state_d;
  logic [LATENCY-1:0][WIDTH-1:0] exp_q;
  logic [LATENCY-1:0]            vld_q;
  logic                          fill_done;
  logic                          cmp_en;
  logic                          mismatch;
  logic                          fail_q, fail_d;
  logic [ERRW-1:0]               err_q, err_d;
  logic [15:0]                   chk_q, chk_d;

  // With a single stage the pipeline is full as soon as FILL is entered.
  generate
    if (LATENCY == 1) begin : g_lat_one
      assign fill_done = 1'b1;
    end else begin : g_lat_many
      assign fill_done = vld_q[LATENCY-2];
    end
  endgenerate

  assign cmp_en   = en & vld_q[LATENCY-1];
  assign mismatch = cmp_en & (q_obs != exp_q[LATENCY-1]);

  // Next-state logic: any disabled edge drops back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = FILL;
      FILL:    if (!en) state_d = IDLE;
               else if (fill_done) state_d = CHECK;
      CHECK:   if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Expected-value pipeline; a disabled edge invalidates every stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q <= '0;
      vld_q <= '0;
    end else if (en) begin
      exp_q[0] <= d_obs;
      vld_q[0] <= 1'b1;
      for (int i = 1; i < LATENCY; i++) begin
        exp_q[i] <= exp_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end else begin
      vld_q <= '0;
    end
  end

  // Counter/flag update; clr wins over a same-edge comparison.
  always_comb begin
    chk_d  = chk_q;
    err_d  = err_q;
    fail_d = fail_q;
    if (clr) begin
      chk_d  = '0;
      err_d  = '0;
      fail_d = 1'b0;
    end else if (cmp_en) begin
      if (chk_q != 16'hFFFF) chk_d = chk_q + 16'd1;
      if (mismatch) begin
        if (err_q != {ERRW{1'b1}}) err_d = err_q + 1'b1;
        fail_d = 1'b1;
      end
    end
  end

  // Counter and sticky flag registers; they hold while en is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chk_q  <= '0;
      err_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      chk_q  <= chk_d;
      err_q  <= err_d;
      fail_q <= fail_d;
    end
  end

`ifdef REG_PATH_CHECKER_FIRST_ERR_EN
  logic [WIDTH-1:0] fexp_q;
  logic [WIDTH-1:0] fobs_q;

  // Capture only the mismatch that first sets fail; later ones are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fexp_q <= '0;
      fobs_q <= '0;
    end else if (clr) begin
      fexp_q <= '0;
      fobs_q <= '0;
    end else if (mismatch && !fail_q) begin
      fexp_q <= exp_q[LATENCY-1];
      fobs_q <= q_obs;
    end
  end

  assign first_exp = fexp_q;
  assign first_obs = fobs_q;
`else
  assign first_exp = '0;
  assign first_obs = '0;
`endif

  assign busy     = state_q[0];
  assign checking = state_q[1];
  assign fail     = fail_q;
  assign err_cnt  = err_q;
  assign chk_cnt  = chk_q;

endmodule

// File: tb/tb_reg_path_checker.sv
// tb_reg_path_checker: drives two checker instances (LATENCY=1/ERRW=8 and
// LATENCY=3/ERRW=2) with shared stimulus and compares them against a
// behavioural model built from a stimulus history and enabled-run length.
module tb_reg_path_checker;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] d = '0;
  logic [7:0] qA = '0;
  logic [7:0] qB = '0;

  logic       busyA, checkingA, failA, busyB, checkingB, failB;
  logic [7:0] errA;
  logic [1:0] errB;
  logic [15:0] chkA, chkB;
  logic [7:0] fexpA, fobsA, fexpB, fobsB;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int lat[2]    = '{1, 3};
  int errMax[2] = '{255, 3};
  int mChk[2];
  int mErr[2];
  bit mFail[2];
  int mFirstExp[2];
  int mFirstObs[2];
  int runLen;
  int hist[$];

  reg_path_checker #(.WIDTH(8), .LATENCY(1), .ERRW(8)) dutA (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d_obs(d), .q_obs(qA),
    .busy(busyA), .checking(checkingA), .fail(failA), .err_cnt(errA),
    .chk_cnt(chkA), .first_exp(fexpA), .first_obs(fobsA)
  );

  reg_path_checker #(.WIDTH(8), .LATENCY(3), .ERRW(2)) dutB (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d_obs(d), .q_obs(qB),
    .busy(busyB), .checking(checkingB), .fail(failB), .err_cnt(errB),
    .chk_cnt(chkB), .first_exp(fexpB), .first_obs(fobsB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int u = 0; u < 2; u++) begin
      mChk[u] = 0; mErr[u] = 0; mFail[u] = 1'b0;
      mFirstExp[u] = 0; mFirstObs[u] = 0;
    end
    runLen = 0;
    hist.delete();
  endfunction

  // Value a correct path would present now (random while the path is not yet primed).
  function automatic int goodQ(input int u);
    if (runLen >= lat[u]) return hist[hist.size() - lat[u]];
    return int'($urandom_range(0, 255));
  endfunction

  // One clock edge as seen by the model, using the inputs in force at that edge.
  function automatic void modelEdge();
    int q, e;
    for (int u = 0; u < 2; u++) begin
      q = (u == 0) ? int'(qA) : int'(qB);
      if (clr) begin
        mChk[u] = 0; mErr[u] = 0; mFail[u] = 1'b0;
        mFirstExp[u] = 0; mFirstObs[u] = 0;
      end else if (en && runLen >= lat[u]) begin
        e = hist[hist.size() - lat[u]];
        if (mChk[u] < 65535) mChk[u]++;
        if (q != e) begin
          if (mErr[u] < errMax[u]) mErr[u]++;
          if (!mFail[u]) begin
            mFirstExp[u] = e;
            mFirstObs[u] = q;
          end
          mFail[u] = 1'b1;
        end
      end
    end
    if (en) begin
      hist.push_back(int'(d));
      if (runLen < 1000) runLen++;
    end else begin
      runLen = 0;
    end
    if (hist.size() > 16) void'(hist.pop_front());
  endfunction

  task automatic checkOne(input int u, input logic b, input logic c, input logic f,
                          input int err, input int chk, input int fe, input int fo);
    string n;
    int chkThresh;
    n = (u == 0) ? "A" : "B";
    chkThresh = (lat[u] < 2) ? 2 : lat[u];
    checkOutput({n, ".busy"}, b, runLen >= 1);
    checkOutput({n, ".checking"}, c, runLen >= chkThresh);
    checkOutput({n, ".fail"}, f, mFail[u]);
    checkOutput({n, ".err_cnt"}, err, mErr[u]);
    checkOutput({n, ".chk_cnt"}, chk, mChk[u]);
`ifdef REG_PATH_CHECKER_FIRST_ERR_EN
    checkOutput({n, ".first_exp"}, fe, mFirstExp[u]);
    checkOutput({n, ".first_obs"}, fo, mFirstObs[u]);
`else
    checkOutput({n, ".first_exp"}, fe, 0);
    checkOutput({n, ".first_obs"}, fo, 0);
`endif
  endtask

  task automatic checkDut();
    checkOne(0, busyA, checkingA, failA, int'(errA), int'(chkA), int'(fexpA), int'(fobsA));
    checkOne(1, busyB, checkingB, failB, int'(errB), int'(chkB), int'(fexpB), int'(fobsB));
  endtask

  // Drive one cycle; a negative q value means "what a correct path would output".
  task automatic applyStimulus(input bit e, input bit c, input int dv, input int qa, input int qb);
    en  = e;
    clr = c;
    d   = dv[7:0];
    qA  = (qa < 0) ? goodQ(0) : qa;
    qB  = (qb < 0) ? goodQ(1) : qb;
    @(posedge clk);
    modelEdge();
    #1;
    checkDut();
  endtask

  task automatic doReset();
    rstn = 1'b0;
    en   = 1'b0;
    clr  = 1'b0;
    modelReset();
    #1;
    checkDut();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int bad, qa, qb;
    #2;
    // Reset state
    doReset();

    // Correct DFF at LATENCY=1
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, i, -1, -1);
    checkOutput("s1.chkA", chkA, 4);
    checkOutput("s1.failA", failA, 0);
    checkOutput("s1.errA", errA, 0);

    // Injected error on the third comparison (expected 2, observed 7)
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, i, (i == 3) ? 7 : -1, -1);
      if (i == 3) begin
        checkOutput("s2.failA", failA, 1);
        checkOutput("s2.errA", errA, 1);
`ifdef REG_PATH_CHECKER_FIRST_ERR_EN
        checkOutput("s2.fexpA", fexpA, 2);
        checkOutput("s2.fobsA", fobsA, 7);
`else
        checkOutput("s2.fexpA", fexpA, 0);
        checkOutput("s2.fobsA", fobsA, 0);
`endif
      end
    end

    // LATENCY=3 fill from IDLE
    doReset();
    for (int e = 1; e <= 4; e++) begin
      applyStimulus(1, 0, 8'h40 + e, -1, -1);
      checkOutput($sformatf("s3.chkB@%0d", e), chkB, (e >= 4) ? 1 : 0);
      checkOutput($sformatf("s3.checkingB@%0d", e), checkingB, (e >= 3) ? 1 : 0);
    end

    // Single-cycle en drop with garbage on q, then a full refill
    applyStimulus(0, 0, 8'h99, 8'hA5, 8'h5A);
    checkOutput("s4.busyB", busyB, 0);
    checkOutput("s4.errB", errB, 0);
    for (int e = 1; e <= 4; e++) begin
      applyStimulus(1, 0, 8'h60 + e, -1, -1);
      checkOutput($sformatf("s4.chkB@%0d", e), chkB, (e >= 4) ? 2 : 1);
    end

    // Saturation at ERRW=2, then clr against a same-edge mismatch
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, i, -1, -1);
    for (int i = 0; i < 5; i++) begin
      bad = goodQ(1) ^ 8'h5A;
      applyStimulus(1, 0, 8'h10 + i, -1, bad);
    end
    checkOutput("s5.errB", errB, 3);
    checkOutput("s5.failB", failB, 1);
    checkOutput("s5.chkB", chkB, 5);
    bad = goodQ(1) ^ 8'h3C;
    applyStimulus(1, 1, 8'h20, -1, bad);
    checkOutput("s5.clr.errB", errB, 0);
    checkOutput("s5.clr.failB", failB, 0);
    checkOutput("s5.clr.chkB", chkB, 0);

    // Async reset between edges while checking with two errors
    doReset();
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, i, -1, -1);
    for (int i = 0; i < 2; i++) begin
      bad = goodQ(0) ^ 8'hFF;
      applyStimulus(1, 0, 8'h30 + i, bad, -1);
    end
    checkOutput("s6.errA.pre", errA, 2);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("s6.busyA", busyA, 0);
    checkOutput("s6.checkingA", checkingA, 0);
    checkOutput("s6.failA", failA, 0);
    checkOutput("s6.errA", errA, 0);
    checkOutput("s6.chkA", chkA, 0);
    checkOutput("s6.fexpA", fexpA, 0);
    checkOutput("s6.fobsA", fobsA, 0);
    checkOutput("s6.busyB", busyB, 0);
    checkOutput("s6.chkB", chkB, 0);
    doReset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      qa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : -1;
      qb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : -1;
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                    int'($urandom_range(0, 255)), qa, qb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
